// File: rtl/vga_pkg.sv
// Shared constants for the VGA/DVI raster timing generator: standard mode
// tables, sync polarity values and a helper for axis totals.
package vga_pkg;

  localparam logic POL_LOW  = 1'b0;
  localparam logic POL_HIGH = 1'b1;

  // 640x480@60, 25.175 MHz pixel clock, negative syncs
  localparam int   VGA_H_PIX  = 640;
  localparam int   VGA_H_FP   = 16;
  localparam int   VGA_H_SYNC = 96;
  localparam int   VGA_H_BP   = 48;
  localparam int   VGA_V_PIX  = 480;
  localparam int   VGA_V_FP   = 10;
  localparam int   VGA_V_SYNC = 2;
  localparam int   VGA_V_BP   = 33;
  localparam logic VGA_H_POL  = POL_LOW;
  localparam logic VGA_V_POL  = POL_LOW;

  // 800x600@60, 40 MHz pixel clock, positive syncs
  localparam int   SVGA_H_PIX  = 800;
  localparam int   SVGA_H_FP   = 40;
  localparam int   SVGA_H_SYNC = 128;
  localparam int   SVGA_H_BP   = 88;
  localparam int   SVGA_V_PIX  = 600;
  localparam int   SVGA_V_FP   = 1;
  localparam int   SVGA_V_SYNC = 4;
  localparam int   SVGA_V_BP   = 23;
  localparam logic SVGA_H_POL  = POL_HIGH;
  localparam logic SVGA_V_POL  = POL_HIGH;

  function automatic int axis_total(input int pix, input int fp, input int sync, input int bp);
    return pix + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_ctr.sv
// One raster axis counter: counts 0..TOTAL-1 on inc and flags the last position
// so the caller can chain the next axis off it.
module vga_axis_ctr
  import vga_pkg::*;
#(
  parameter int  TOTAL = 800,
  localparam int W     = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // wrap is purely positional; the caller qualifies it with its own enable
  assign wrap  = (count_q == LAST);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = wrap ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: syncs, data enable, coordinates and
// line/frame strobes, all registered together and advanced on a pixel enable.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_PIX   = VGA_H_PIX,
  parameter int   H_FP    = VGA_H_FP,
  parameter int   H_SYNC  = VGA_H_SYNC,
  parameter int   H_BP    = VGA_H_BP,
  parameter int   V_PIX   = VGA_V_PIX,
  parameter int   V_FP    = VGA_V_FP,
  parameter int   V_SYNC  = VGA_V_SYNC,
  parameter int   V_BP    = VGA_V_BP,
  parameter logic H_POL   = VGA_H_POL,
  parameter logic V_POL   = VGA_V_POL,
  parameter int   FRAME_W = 16,
  localparam int  H_TOTAL = axis_total(H_PIX, H_FP, H_SYNC, H_BP),
  localparam int  V_TOTAL = axis_total(V_PIX, V_FP, V_SYNC, V_BP),
  localparam int  X_W     = $clog2(H_TOTAL),
  localparam int  Y_W     = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic               sol,
  output logic               sof,
  output logic [FRAME_W-1:0] frame
);

  if (H_PIX < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_PIX < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_param_check
    $error("vga_timing_gen: active, porch and sync parameters must all be >= 1");
  end

  localparam logic [X_W-1:0] H_ACT_END  = X_W'(H_PIX);
  localparam logic [X_W-1:0] H_SYNC_BEG = X_W'(H_PIX + H_FP);
  localparam logic [X_W-1:0] H_SYNC_END = X_W'(H_PIX + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] V_ACT_END  = Y_W'(V_PIX);
  localparam logic [Y_W-1:0] V_SYNC_BEG = Y_W'(V_PIX + V_FP);
  localparam logic [Y_W-1:0] V_SYNC_END = Y_W'(V_PIX + V_FP + V_SYNC);

  logic [X_W-1:0] h;
  logic [Y_W-1:0] v;
  logic           h_wrap;
  logic           v_wrap;
  logic           v_inc;

  assign v_inc = ce & h_wrap;

  vga_axis_ctr #(.TOTAL(H_TOTAL)) u_h_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ce),
    .count (h),
    .wrap  (h_wrap)
  );

  vga_axis_ctr #(.TOTAL(V_TOTAL)) u_v_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (v_inc),
    .count (v),
    .wrap  (v_wrap)
  );

  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic               de_q, de_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               sol_q, sol_d;
  logic               sof_q, sof_d;

  // frame_cnt_q runs one pixel ahead; frame_q samples it with x/y so the
  // count seen at sof already includes the frame that just ended
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    frame_d     = frame_q;
    x_d         = x_q;
    y_d         = y_q;
    de_d        = de_q;
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    sol_d       = sol_q;
    sof_d       = sof_q;
    if (ce) begin
      x_d     = h;
      y_d     = v;
      frame_d = frame_cnt_q;
      de_d    = (h < H_ACT_END) && (v < V_ACT_END);
      hsync_d = (h >= H_SYNC_BEG && h < H_SYNC_END) ? H_POL : ~H_POL;
      vsync_d = (v >= V_SYNC_BEG && v < V_SYNC_END) ? V_POL : ~V_POL;
      sol_d   = (h == '0);
      sof_d   = (h == '0) && (v == '0);
      if (h_wrap && v_wrap) begin
        frame_cnt_d = frame_cnt_q + FRAME_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      frame_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      de_q        <= 1'b0;
      hsync_q     <= ~H_POL;
      vsync_q     <= ~V_POL;
      sol_q       <= 1'b0;
      sof_q       <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      frame_q     <= frame_d;
      x_q         <= x_d;
      y_q         <= y_d;
      de_q        <= de_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      sol_q       <= sol_d;
      sof_q       <= sof_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign de    = de_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign sol   = sol_q;
  assign sof   = sof_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-raster instances (negative syncs with a
// wide frame counter, positive syncs with a 2-bit one) checked against a pixel-count model.
module tb_vga_timing_gen;

  localparam int H_PIX = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_PIX = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int H_TOT = H_PIX + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_PIX + V_FP + V_SYNC + V_BP;
  localparam int F_TOT = H_TOT * V_TOT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;

  logic       hs_a, vs_a, de_a, sol_a, sof_a;
  logic [3:0] x_a;
  logic [2:0] y_a;
  logic [15:0] fr_a;
  logic       hs_b, vs_b, de_b, sol_b, sof_b;
  logic [3:0] x_b;
  logic [2:0] y_b;
  logic [1:0] fr_b;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_PIX(H_PIX), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_PIX(V_PIX), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_POL(1'b0), .V_POL(1'b0), .FRAME_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .ce(ce), .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .x(x_a), .y(y_a), .sol(sol_a), .sof(sof_a), .frame(fr_a)
  );

  vga_timing_gen #(
    .H_PIX(H_PIX), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_PIX(V_PIX), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_POL(1'b1), .V_POL(1'b1), .FRAME_W(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .ce(ce), .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .x(x_b), .y(y_b), .sol(sol_b), .sof(sof_b), .frame(fr_b)
  );

  int errors = 0;
  int checks = 0;

  // model: number of pixels emitted since reset; m_p is the one on display
  bit m_started = 1'b0;
  int m_n = 0;
  int m_p = 0;

  int cyc = 0;
  int last_rise = -1;
  int period_exp = 0;
  logic prev_sof = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_dut(input string pfx, input logic pol, input int fw,
                           input logic [3:0] xo, input logic [2:0] yo, input logic deo,
                           input logic hso, input logic vso, input logic solo,
                           input logic sofo, input logic [15:0] fro);
    int h, v, f;
    logic ex_de, ex_hs, ex_vs, ex_sol, ex_sof;
    if (!m_started) begin
      h = 0; v = 0; f = 0;
      ex_de = 1'b0; ex_sol = 1'b0; ex_sof = 1'b0;
      ex_hs = ~pol; ex_vs = ~pol;
    end else begin
      h = m_p % H_TOT;
      v = (m_p / H_TOT) % V_TOT;
      f = (m_p / F_TOT) % (1 << fw);
      ex_de  = (h < H_PIX) && (v < V_PIX);
      ex_hs  = (h >= H_PIX + H_FP && h < H_PIX + H_FP + H_SYNC) ? pol : ~pol;
      ex_vs  = (v >= V_PIX + V_FP && v < V_PIX + V_FP + V_SYNC) ? pol : ~pol;
      ex_sol = (h == 0);
      ex_sof = (h == 0) && (v == 0);
    end
    check_eq({pfx, ".x"},     32'(xo),    32'(h));
    check_eq({pfx, ".y"},     32'(yo),    32'(v));
    check_eq({pfx, ".de"},    32'(deo),   32'(ex_de));
    check_eq({pfx, ".hsync"}, 32'(hso),   32'(ex_hs));
    check_eq({pfx, ".vsync"}, 32'(vso),   32'(ex_vs));
    check_eq({pfx, ".sol"},   32'(solo),  32'(ex_sol));
    check_eq({pfx, ".sof"},   32'(sofo),  32'(ex_sof));
    check_eq({pfx, ".frame"}, 32'(fro),   32'(f));
  endtask

  task automatic step(input logic ce_v, input logic rst_v);
    ce = ce_v;
    rst_n = rst_v;
    @(posedge clk);
    cyc++;
    if (!rst_v) begin
      m_started = 1'b0;
      m_n = 0;
      m_p = 0;
      last_rise = -1;
    end else if (ce_v) begin
      m_p = m_n;
      m_started = 1'b1;
      m_n++;
    end
    @(negedge clk);
    check_dut("a", 1'b0, 16, x_a, y_a, de_a, hs_a, vs_a, sol_a, sof_a, fr_a);
    check_dut("b", 1'b1, 2, x_b, y_b, de_b, hs_b, vs_b, sol_b, sof_b, 16'(fr_b));
    if (sof_a && !prev_sof) begin
      if (last_rise >= 0 && period_exp > 0)
        check_eq("sof_period", 32'(cyc - last_rise), 32'(period_exp));
      last_rise = cyc;
    end
    prev_sof = sof_a;
  endtask

  initial begin
    bit reached;

    repeat (4) step(1'($urandom_range(0, 1)), 1'b0);

    // continuous ce: five frames so the 2-bit counter wraps 3 -> 0
    period_exp = F_TOT;
    for (int i = 0; i < 5 * F_TOT + 4; i++) step(1'b1, 1'b1);

    // ce one clock in three
    period_exp = 3 * F_TOT;
    last_rise = -1;
    for (int i = 0; i < 2 * 3 * F_TOT + 12; i++) step(1'(i % 3 == 0), 1'b1);

    // reset while inside both sync pulses at (11,5)
    period_exp = 0;
    reached = 1'b0;
    for (int i = 0; i < 2 * F_TOT && !reached; i++) begin
      step(1'b1, 1'b1);
      if (m_started && (m_p % F_TOT) == 5 * H_TOT + 11) reached = 1'b1;
    end
    check_eq("reach_11_5", 32'(reached), 32'd1);
    step(1'b1, 1'b0);
    check_eq("rst_hsync_a", 32'(hs_a), 32'd1);
    check_eq("rst_vsync_a", 32'(vs_a), 32'd1);
    period_exp = F_TOT;
    for (int i = 0; i < F_TOT + 20; i++) step(1'b1, 1'b1);

    // randomized ce with occasional reset
    period_exp = 0;
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 299) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
